// File: rtl/vga_defs.sv
// Shared 640x480@60 timing constants, tile-map geometry, tile codes and palette.
package vga_defs;

  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] V_TOTAL      = 10'd525;
  localparam logic [9:0] H_SHOW_START = 10'd144;
  localparam logic [9:0] V_SHOW_START = 10'd35;
  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] H_SHOW_END   = H_SHOW_START + H_ACTIVE - 10'd1;
  localparam logic [9:0] V_SHOW_END   = V_SHOW_START + V_ACTIVE - 10'd1;

  localparam int         TILE      = 10;
  localparam int         MAP_W     = 64;
  localparam int         MAP_H     = 48;
  localparam int         MAP_DEPTH = MAP_W * MAP_H;
  localparam logic [3:0] TILE_LAST = 4'(TILE - 1);
  localparam logic [11:0] MAP_LIMIT = 12'(MAP_DEPTH);

  localparam logic [3:0] TC_EMPTY = 4'd0;
  localparam logic [3:0] TC_BRICK = 4'd1;
  localparam logic [3:0] TC_STEEL = 4'd2;
  localparam logic [3:0] TC_WATER = 4'd3;
  localparam logic [3:0] TC_GRASS = 4'd4;
  localparam logic [3:0] TC_BASE  = 4'd5;

  localparam logic [23:0] C_BLACK   = 24'h000000;
  localparam logic [23:0] C_BRICK   = 24'hB22222;
  localparam logic [23:0] C_MORTAR  = 24'h808080;
  localparam logic [23:0] C_STEEL   = 24'hA0A0A0;
  localparam logic [23:0] C_EDGE    = 24'hFFFFFF;
  localparam logic [23:0] C_WATER   = 24'h0040FF;
  localparam logic [23:0] C_GRASS   = 24'h00A000;
  localparam logic [23:0] C_BASE    = 24'hFFD700;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;

  // Unknown codes render magenta so stray map writes are easy to spot on screen.
  function automatic logic [23:0] tile_rgb(input logic [3:0] code, input logic [3:0] sx,
                                           input logic [3:0] sy);
    logic [23:0] c;
    case (code)
      TC_EMPTY: c = C_BLACK;
      TC_BRICK: c = (sx == 4'd0 || sy == 4'd0) ? C_MORTAR : C_BRICK;
      TC_STEEL: c = (sx == 4'd0 || sy == 4'd0 || sx == TILE_LAST || sy == TILE_LAST)
                    ? C_EDGE : C_STEEL;
      TC_WATER: c = C_WATER;
      TC_GRASS: c = C_GRASS;
      TC_BASE:  c = C_BASE;
      default:  c = C_MAGENTA;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// 3072x4 simple dual-port tile map: one write port, one registered read port, read-first.
module tile_map_ram
  import vga_defs::*;
(
  input  logic        clk_25m,
  input  logic        i_we,
  input  logic [11:0] i_waddr,
  input  logic [3:0]  i_wdata,
  input  logic [11:0] i_raddr,
  output logic [3:0]  o_rdata
);

  logic [3:0] r_mem [MAP_DEPTH];

  // Out-of-range writes are dropped rather than aliased onto real rows.
  always_ff @(posedge clk_25m) begin
    if (i_we && (i_waddr < MAP_LIMIT)) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/tile_pixel_gen.sv
// Maps raw VGA scan counters to 10x10 map tiles and emits pipelined RGB with
// hsync/vsync delayed to match the 3-cycle pixel latency.
module tile_pixel_gen
  import vga_defs::*;
(
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        map_we,
  input  logic [11:0] map_waddr,
  input  logic [3:0]  map_wdata,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out
);

  logic [3:0]  r_sub_x, r_sub_y;
  logic [5:0]  r_tile_x, r_tile_y;
  logic        w_active;
  logic [11:0] r_addr;
  logic [3:0]  r_sx1, r_sy1, r_sx2, r_sy2;
  logic [1:0]  r_vld_pipe;
  logic [3:0]  w_code;
  logic [23:0] r_rgb;
  logic [2:0]  r_hs_d, r_vs_d;

  assign w_active = (hcnt >= H_SHOW_START) && (hcnt <= H_SHOW_END) &&
                    (vcnt >= V_SHOW_START) && (vcnt <= V_SHOW_END);

  // Counters hold the tile position of the pixel currently on hcnt/vcnt.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_x  <= '0;
      r_tile_x <= '0;
    end else if (hcnt == H_SHOW_START - 10'd1) begin
      r_sub_x  <= '0;
      r_tile_x <= '0;
    end else if (hcnt >= H_SHOW_START && hcnt < H_SHOW_END) begin
      if (r_sub_x == TILE_LAST) begin
        r_sub_x  <= '0;
        r_tile_x <= r_tile_x + 6'd1;
      end else begin
        r_sub_x  <= r_sub_x + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_y  <= '0;
      r_tile_y <= '0;
    end else if (hcnt == H_TOTAL - 10'd1) begin
      if (vcnt == V_SHOW_START - 10'd1) begin
        r_sub_y  <= '0;
        r_tile_y <= '0;
      end else if (vcnt >= V_SHOW_START && vcnt < V_SHOW_END) begin
        if (r_sub_y == TILE_LAST) begin
          r_sub_y  <= '0;
          r_tile_y <= r_tile_y + 6'd1;
        end else begin
          r_sub_y  <= r_sub_y + 4'd1;
        end
      end
    end
  end

  // S1: map address and sub-tile position; S2: RAM read; S3: palette.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_sx1      <= '0;
      r_sy1      <= '0;
      r_sx2      <= '0;
      r_sy2      <= '0;
      r_vld_pipe <= '0;
      r_rgb      <= '0;
    end else begin
      r_addr     <= {r_tile_y, 6'b0} + {6'b0, r_tile_x};
      r_sx1      <= r_sub_x;
      r_sy1      <= r_sub_y;
      r_sx2      <= r_sx1;
      r_sy2      <= r_sy1;
      r_vld_pipe <= {r_vld_pipe[0], w_active};
      r_rgb      <= r_vld_pipe[1] ? tile_rgb(w_code, r_sx2, r_sy2) : C_BLACK;
    end
  end

  tile_map_ram u_map (
    .clk_25m (clk_25m),
    .i_we    (map_we),
    .i_waddr (map_waddr),
    .i_wdata (map_wdata),
    .i_raddr (r_addr),
    .o_rdata (w_code)
  );

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_d <= 3'b111;
      r_vs_d <= 3'b111;
    end else begin
      r_hs_d <= {r_hs_d[1:0], hsync_in};
      r_vs_d <= {r_vs_d[1:0], vsync_in};
    end
  end

  assign {red, green, blue} = r_rgb;
  assign hsync_out = r_hs_d[2];
  assign vsync_out = r_vs_d[2];

endmodule
